// File: rtl/nios2_cordic_slave_arbiter.sv
// Two-master round-robin arbiter in front of one single-cycle Avalon-MM read slave.
// Optional ARB_LOCK_EN adds per-master lock inputs with a MAX_LOCK grant limit.
module nios2_cordic_slave_arbiter #(
  parameter int ADDR_W   = 1,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
`ifdef ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_readdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_q;
  logic   gnt_q;
  logic   last_q;
  logic   win;
  logic   gnt_read;

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] lock_cnt_q;
  logic          lock_own_q;
  logic          lock_act;
  logic          gnt_lock;

  assign lock_act = (lock_cnt_q != '0) &&
                    (lock_cnt_q < CW'(MAX_LOCK));
  assign gnt_lock = gnt_q ? m1_lock : m0_lock;
`else
  logic unused_max_lock;
  assign unused_max_lock = ^MAX_LOCK;
`endif

  assign gnt_read = gnt_q ? m1_read : m0_read;

  always_comb begin
    win = ~last_q;
    unique case (1'b1)
      (m0_read && !m1_read): win = 1'b0;
      (m1_read && !m0_read): win = 1'b1;
      default: begin
`ifdef ARB_LOCK_EN
        if (lock_act) win = lock_own_q;
`endif
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      gnt_q          <= 1'b0;
      last_q         <= 1'b1;
      s_address      <= '0;
      m0_waitrequest <= 1'b1;
      m1_waitrequest <= 1'b1;
      m0_readdata    <= '0;
      m1_readdata    <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q     <= '0;
      lock_own_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (m0_read || m1_read) begin
            gnt_q     <= win;
            last_q    <= win;
            s_address <= win ? m1_address : m0_address;
            state_q   <= ACCESS;
`ifdef ARB_LOCK_EN
            if (win != lock_own_q) lock_cnt_q <= '0;
`endif
          end
        end
        ACCESS: begin
          // A dropped read aborts; last_q keeps the new grant
          if (gnt_read) begin
            if (gnt_q) begin
              m1_readdata    <= s_readdata;
              m1_waitrequest <= 1'b0;
            end else begin
              m0_readdata    <= s_readdata;
              m0_waitrequest <= 1'b0;
            end
            state_q <= DONE;
          end else begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          m0_waitrequest <= 1'b1;
          m1_waitrequest <= 1'b1;
          state_q        <= IDLE;
`ifdef ARB_LOCK_EN
          if (gnt_lock) begin
            lock_own_q <= gnt_q;
            if (lock_cnt_q != CW'(MAX_LOCK))
              lock_cnt_q <= lock_cnt_q + 1'b1;
          end else begin
            lock_cnt_q <= '0;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
